// File: rtl/result_piso.sv
// ---------------------------------------------------------------------------
// result_piso
//
// Parallel-in serial-out drain for systolic-array result rows. A full row of
// DEPTH lanes is captured on an accepted `load` and emitted one lane per beat
// on a valid/ready stream, lane 0 first.
//
// Optional feature macro: PISO_DOUBLE_BUF_EN
//   Undefined : single row buffer; load_ready only in IDLE, so one idle cycle
//               separates back-to-back rows.
//   Defined   : adds a one-row shadow buffer so a following row can be queued
//               during SHIFT and rows stream with no bubble.
//
// Ports
//   clk        in   clock, rising edge
//   rst_piso   in   synchronous active-high reset
//   load       in   row capture strobe (honoured when load_ready=1)
//   par_in     in   row data, lane k = par_in[k*DATA_WIDTH +: DATA_WIDTH]
//   load_ready out  a load presented this cycle will be accepted
//   ser_out    out  data of the lane currently offered
//   ser_valid  out  ser_out is valid
//   ser_ready  in   downstream accepts the current beat
//   ser_last   out  current beat is lane DEPTH-1
//   lane_idx   out  index of the lane on ser_out
//   busy       out  a row is being drained
//   overrun    out  sticky: a load was dropped since reset
// ---------------------------------------------------------------------------
module result_piso #(
  parameter int DEPTH       = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_piso,
  input  logic                        load,
  input  logic [DEPTH*DATA_WIDTH-1:0] par_in,
  output logic                        load_ready,
  output logic [DATA_WIDTH-1:0]       ser_out,
  output logic                        ser_valid,
  input  logic                        ser_ready,
  output logic                        ser_last,
  output logic [COUNT_WIDTH-1:0]      lane_idx,
  output logic                        busy,
  output logic                        overrun
);

  localparam int ROW_W = DEPTH * DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LAST_LANE = COUNT_WIDTH'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [ROW_W-1:0]         shift_q, shift_d;
  logic [COUNT_WIDTH-1:0]   lane_q, lane_d;
  logic                     overrun_q, overrun_d;

`ifdef PISO_DOUBLE_BUF_EN
  logic [ROW_W-1:0]         shadow_q, shadow_d;
  logic                     shadow_full_q, shadow_full_d;
`endif

  logic accept;
  logic beat;
  logic last_beat;

  // Lane 0 of the remaining row always sits in the low slice; each beat
  // shifts the row down by one lane.
  assign ser_valid = (state_q == S_SHIFT);
  assign busy      = (state_q == S_SHIFT);
  assign ser_out   = ser_valid ? shift_q[DATA_WIDTH-1:0] : '0;
  assign lane_idx  = lane_q;
  assign ser_last  = ser_valid && (lane_q == LAST_LANE);
  assign overrun   = overrun_q;

`ifdef PISO_DOUBLE_BUF_EN
  assign load_ready = !shadow_full_q;
`else
  assign load_ready = (state_q == S_IDLE);
`endif

  assign accept    = load && load_ready;
  assign beat      = ser_valid && ser_ready;
  assign last_beat = beat && (lane_q == LAST_LANE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    lane_d    = lane_q;
    overrun_d = overrun_q;
`ifdef PISO_DOUBLE_BUF_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif

    if (load && !load_ready) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = par_in;
          lane_d  = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (last_beat) begin
          lane_d  = '0;
          state_d = S_IDLE;
`ifdef PISO_DOUBLE_BUF_EN
          // A queued row takes priority; otherwise a load arriving on the
          // last beat goes straight into the shift register.
          if (shadow_full_q) begin
            shift_d       = shadow_q;
            shadow_full_d = 1'b0;
            state_d       = S_SHIFT;
          end else if (accept) begin
            shift_d = par_in;
            state_d = S_SHIFT;
          end
`endif
        end else if (beat) begin
          lane_d  = lane_q + 1'b1;
          shift_d = {{DATA_WIDTH{1'b0}}, shift_q[ROW_W-1:DATA_WIDTH]};
        end

`ifdef PISO_DOUBLE_BUF_EN
        // Mid-row load: park the row in the shadow until the current one ends.
        if (accept && !last_beat) begin
          shadow_d      = par_in;
          shadow_full_d = 1'b1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_piso) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      lane_q    <= '0;
      overrun_q <= 1'b0;
`ifdef PISO_DOUBLE_BUF_EN
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      lane_q    <= lane_d;
      overrun_q <= overrun_d;
`ifdef PISO_DOUBLE_BUF_EN
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

endmodule
